// File: rtl/conv_sched_pkg.sv
// Shared types and sizing for the multi-layer conv sequencer.
// The layer descriptor layout matches the host register packing {chi, cho, stride, ifm_size}.
package conv_sched_pkg;

   localparam int CHN_WIDTH    = 4;
   localparam int FMS_WIDTH    = 8;
   localparam int MAX_LAYERS   = 8;
   localparam int DRAIN_CYCLES = 5;
   localparam int LID_WIDTH    = $clog2(MAX_LAYERS);
   localparam int DESC_WIDTH   = 2*CHN_WIDTH + 1 + FMS_WIDTH;
   localparam int DCNT_WIDTH   = $clog2(DRAIN_CYCLES + 1);

   typedef struct packed {
      logic [CHN_WIDTH-1:0] chi;
      logic [CHN_WIDTH-1:0] cho;
      logic                 stride;
      logic [FMS_WIDTH-1:0] ifm_size;
   } layer_desc_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4
   } sched_state_e;

   // A zero channel count would make the conv controller's down-counter underflow.
   function automatic logic desc_valid(input layer_desc_t d);
      return (d.chi != {CHN_WIDTH{1'b0}}) && (d.cho != {CHN_WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/sched_desc_rf.sv
// Layer descriptor table: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the host must load them before use.
module sched_desc_rf
   import conv_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 we,
   input  logic [LID_WIDTH-1:0] waddr,
   input  layer_desc_t          wdata,
   input  logic [LID_WIDTH-1:0] raddr,
   output layer_desc_t          rdata
);

   layer_desc_t mem_r [MAX_LAYERS];

   // Descriptor storage write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/conv_layer_sched.sv
// Multi-layer sequencer: walks the descriptor table, configures and starts the conv
// controller per layer, waits for conv_done plus the PE pipeline drain tail.
module conv_layer_sched
   import conv_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cfg_we,
   input  logic [LID_WIDTH-1:0]  cfg_addr,
   input  logic [DESC_WIDTH-1:0] cfg_wdata,
   input  logic [LID_WIDTH:0]    num_layers,
   input  logic                  go,
   input  logic                  abort,
   input  logic                  conv_done,
   output logic [CHN_WIDTH-1:0]  chi,
   output logic [CHN_WIDTH-1:0]  cho,
   output logic                  stride,
   output logic [FMS_WIDTH-1:0]  ifm_size,
   output logic                  start_conv,
   output logic                  busy,
   output logic [LID_WIDTH-1:0]  layer_id,
   output logic                  layer_done,
   output logic                  all_done,
   output logic                  err
);

   localparam logic [LID_WIDTH:0]    MAX_NL    = (LID_WIDTH+1)'(MAX_LAYERS);
   localparam logic [LID_WIDTH:0]    ONE_NL    = (LID_WIDTH+1)'(1);
   localparam logic [DCNT_WIDTH-1:0] DCNT_LAST = DCNT_WIDTH'(DRAIN_CYCLES - 1);
   localparam logic [DCNT_WIDTH-1:0] DCNT_ONE  = DCNT_WIDTH'(1);

   sched_state_e          state_r, next_state_s;
   logic [DCNT_WIDTH-1:0] drain_cnt_r, next_cnt_s;
   logic [LID_WIDTH:0]    num_layers_r;
   logic [LID_WIDTH-1:0]  layer_id_r;
   layer_desc_t           rd_desc_s;
   logic                  go_ok_s, last_layer_s, drain_last_s;
   logic                  err_s, layer_done_s, all_done_s;
   logic                  start_conv_r, busy_r, layer_done_r, all_done_r, err_r;
   layer_desc_t           cfg_r;

   sched_desc_rf u_rf (
      .clk   (clk),
      .we    (cfg_we && !busy_r),
      .waddr (cfg_addr),
      .wdata (layer_desc_t'(cfg_wdata)),
      .raddr (layer_id_r),
      .rdata (rd_desc_s)
   );

   assign go_ok_s      = go && (num_layers != {(LID_WIDTH+1){1'b0}}) && (num_layers <= MAX_NL);
   assign last_layer_s = ({1'b0, layer_id_r} == (num_layers_r - ONE_NL));
   assign drain_last_s = (drain_cnt_r == DCNT_LAST);

   // Next-state and pulse decode; abort overrides every state.
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = drain_cnt_r;
      err_s        = 1'b0;
      if (abort) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (go_ok_s) begin
                  next_state_s = ST_LOAD;
               end else if (go) begin
                  err_s = 1'b1;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (desc_valid(rd_desc_s)) begin
                  next_state_s = ST_START;
               end else begin
                  next_state_s = ST_IDLE;
                  err_s        = 1'b1;
               end
            end
            ST_START: next_state_s = ST_RUN;
            ST_RUN: begin
               if (conv_done) begin
                  next_state_s = ST_DRAIN;
                  next_cnt_s   = {DCNT_WIDTH{1'b0}};
               end else begin
                  next_state_s = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_last_s) begin
                  next_state_s = last_layer_s ? ST_IDLE : ST_LOAD;
               end else begin
                  next_cnt_s = drain_cnt_r + DCNT_ONE;
               end
            end
            default: next_state_s = ST_IDLE;
         endcase
      end
      // Pulses are registered, so they are decoded one cycle ahead from the next state.
      layer_done_s = (next_state_s == ST_DRAIN) && (next_cnt_s == DCNT_LAST);
      all_done_s   = layer_done_s && last_layer_s;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= ST_IDLE;
         drain_cnt_r   <= {DCNT_WIDTH{1'b0}};
         num_layers_r  <= {(LID_WIDTH+1){1'b0}};
         layer_id_r    <= {LID_WIDTH{1'b0}};
         cfg_r         <= '0;
         start_conv_r  <= 1'b0;
         busy_r        <= 1'b0;
         layer_done_r  <= 1'b0;
         all_done_r    <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         drain_cnt_r  <= next_cnt_s;
         start_conv_r <= (next_state_s == ST_START);
         busy_r       <= (next_state_s != ST_IDLE);
         layer_done_r <= layer_done_s;
         all_done_r   <= all_done_s;
         err_r        <= err_s;
         if (state_r == ST_IDLE && next_state_s == ST_LOAD) begin
            num_layers_r <= num_layers;
            layer_id_r   <= {LID_WIDTH{1'b0}};
         end else if (state_r == ST_DRAIN && next_state_s == ST_LOAD) begin
            layer_id_r <= layer_id_r + {{(LID_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            layer_id_r <= layer_id_r;
         end
         // Config is captured even for a rejected descriptor so the host can inspect it.
         if (state_r == ST_LOAD && !abort) begin
            cfg_r <= rd_desc_s;
         end else begin
            cfg_r <= cfg_r;
         end
      end
   end

   assign chi        = cfg_r.chi;
   assign cho        = cfg_r.cho;
   assign stride     = cfg_r.stride;
   assign ifm_size   = cfg_r.ifm_size;
   assign start_conv = start_conv_r;
   assign busy       = busy_r;
   assign layer_id   = layer_id_r;
   assign layer_done = layer_done_r;
   assign all_done   = all_done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with hand-computed expectations.
module tb_conv_layer_sched;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [16:0] cfg_wdata;
   logic [3:0]  num_layers;
   logic        go, abort, conv_done;
   logic [3:0]  chi, cho;
   logic        stride;
   logic [7:0]  ifm_size;
   logic        start_conv, busy, layer_done, all_done, err;
   logic [2:0]  layer_id;

   int n_checks = 0;
   int n_errors = 0;
   int n_start = 0, n_ldone = 0, n_adone = 0, n_err = 0;
   int s0, l0, a0, e0;

   logic [3:0] exp_chi [3] = '{4'd2, 4'd4, 4'd15};
   logic [3:0] exp_cho [3] = '{4'd3, 4'd5, 4'd1};
   logic       exp_s   [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] exp_ifm [3] = '{8'd34, 8'd50, 8'd255};

   always #5 clk = ~clk;

   conv_layer_sched dut (
      .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_layers(num_layers), .go(go), .abort(abort), .conv_done(conv_done),
      .chi(chi), .cho(cho), .stride(stride), .ifm_size(ifm_size), .start_conv(start_conv),
      .busy(busy), .layer_id(layer_id), .layer_done(layer_done), .all_done(all_done), .err(err)
   );

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (start_conv) n_start++;
      if (layer_done) n_ldone++;
      if (all_done)   n_adone++;
      if (err)        n_err++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] ci, input logic [3:0] co,
                     input logic s, input logic [7:0] ifm);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = {ci, co, s, ifm};
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_go(input logic [3:0] n);
      num_layers = n; go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic conv_pulse();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int k = 0;
      while (!start_conv && k < 40) begin tick(); k++; end
      check_val(tag, 32'(start_conv), 32'd1);
   endtask

   task automatic wait_ldone(input string tag);
      int k = 0;
      while (!layer_done && k < 40) begin tick(); k++; end
      check_val(tag, 32'(layer_done), 32'd1);
   endtask

   task automatic snap();
      s0 = n_start; l0 = n_ldone; a0 = n_adone; e0 = n_err;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, expected completion");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 17'd0; num_layers = 4'd0;
      go = 1'b0; abort = 1'b0; conv_done = 1'b0;
      tick(2);
      check_val("rst_outs", 32'({chi, cho, stride, ifm_size, start_conv, busy, layer_id,
                                 layer_done, all_done, err}), 32'd0);
      rstn = 1'b1;
      tick();

      // Single layer with latency checks; write while busy must be dropped.
      wr(3'd0, 4'd1, 4'd1, 1'b0, 8'd18);
      pulse_go(4'd1);
      check_val("t1_busy_load", 32'(busy), 32'd1);
      check_val("t1_start_early", 32'(start_conv), 32'd0);
      tick();
      check_val("t1_start_lat", 32'(start_conv), 32'd1);
      check_val("t1_cfg", 32'({chi, cho, stride, ifm_size}), 32'({4'd1, 4'd1, 1'b0, 8'd18}));
      check_val("t1_lid", 32'(layer_id), 32'd0);
      tick();
      check_val("t1_start_once", 32'(start_conv), 32'd0);
      wr(3'd0, 4'd7, 4'd7, 1'b1, 8'd99);
      tick();
      conv_pulse();
      tick(3);
      check_val("t1_ldone_early", 32'(layer_done), 32'd0);
      tick();
      check_val("t1_ldone", 32'({layer_done, all_done, busy}), 32'b111);
      tick();
      check_val("t1_after", 32'({layer_done, all_done, busy}), 32'b000);
      check_val("t1_hold", 32'({chi, ifm_size}), 32'({4'd1, 8'd18}));
      pulse_go(4'd1);
      tick();
      check_val("t1_rerun_cfg", 32'({chi, cho, stride, ifm_size}), 32'({4'd1, 4'd1, 1'b0, 8'd18}));
      tick();
      conv_pulse();
      tick(5);
      check_val("t1_rerun_idle", 32'(busy), 32'd0);

      // Three layers.
      wr(3'd0, 4'd2, 4'd3, 1'b1, 8'd34);
      wr(3'd1, 4'd4, 4'd5, 1'b0, 8'd50);
      wr(3'd2, 4'd15, 4'd1, 1'b1, 8'd255);
      snap();
      pulse_go(4'd3);
      for (int i = 0; i < 3; i++) begin
         wait_start("t2_start");
         check_val("t2_lid", 32'(layer_id), 32'(i));
         check_val("t2_cfg", 32'({chi, cho, stride, ifm_size}),
                   32'({exp_chi[i], exp_cho[i], exp_s[i], exp_ifm[i]}));
         tick(2);
         conv_pulse();
         wait_ldone("t2_ldone");
         check_val("t2_all", 32'(all_done), 32'(i == 2));
         if (i < 2) begin
            tick();
            check_val("t2_gap_load", 32'(start_conv), 32'd0);
            tick();
            check_val("t2_gap_start", 32'(start_conv), 32'd1);
         end
      end
      tick(2);
      check_val("t2_idle", 32'(busy), 32'd0);
      check_val("t2_nstart", 32'(n_start - s0), 32'd3);
      check_val("t2_nldone", 32'(n_ldone - l0), 32'd3);
      check_val("t2_nadone", 32'(n_adone - a0), 32'd1);

      // Bad layer counts.
      snap();
      pulse_go(4'd0);
      check_val("t3_err0", 32'({err, busy}), 32'b10);
      tick();
      check_val("t3_err0_once", 32'({err, busy}), 32'b00);
      pulse_go(4'd9);
      check_val("t3_err9", 32'({err, busy}), 32'b10);
      tick(3);
      check_val("t3_nstart", 32'(n_start - s0), 32'd0);
      check_val("t3_nerr", 32'(n_err - e0), 32'd2);

      // Second descriptor invalid.
      wr(3'd0, 4'd1, 4'd2, 1'b0, 8'd10);
      wr(3'd1, 4'd3, 4'd0, 1'b0, 8'd10);
      snap();
      pulse_go(4'd2);
      wait_start("t4_start");
      tick();
      conv_pulse();
      wait_ldone("t4_ldone");
      check_val("t4_no_all", 32'(all_done), 32'd0);
      tick(2);
      check_val("t4_err", 32'({err, busy, layer_id}), 32'({1'b1, 1'b0, 3'd1}));
      tick(2);
      check_val("t4_nstart", 32'(n_start - s0), 32'd1);
      check_val("t4_nadone", 32'(n_adone - a0), 32'd0);

      // Abort in RUN, then in DRAIN; stray conv_done afterwards.
      wr(3'd0, 4'd1, 4'd1, 1'b0, 8'd18);
      snap();
      pulse_go(4'd1);
      wait_start("t5_start");
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("t5_abort_run", 32'({busy, start_conv}), 32'b00);
      conv_pulse();
      tick(6);
      pulse_go(4'd1);
      wait_start("t5_start2");
      tick();
      conv_pulse();
      tick(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("t5_abort_drain", 32'(busy), 32'd0);
      check_val("t5_hold", 32'({chi, layer_id}), 32'({4'd1, 3'd0}));
      conv_pulse();
      tick(6);
      check_val("t5_nldone", 32'(n_ldone - l0), 32'd0);
      check_val("t5_nadone", 32'(n_adone - a0), 32'd0);
      num_layers = 4'd1; go = 1'b1; abort = 1'b1;
      tick();
      go = 1'b0; abort = 1'b0;
      check_val("t5_go_abort", 32'(busy), 32'd0);
      tick(3);
      check_val("t5_go_abort_nstart", 32'(n_start - s0), 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
